// File: rtl/a2d_intf_if.sv
// Host handshake and SPI pins of the A2D interface, bundled for port connection.
interface a2d_intf_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    modport slave (
        input  strt_cnv, chnnl, MISO,
        output cnv_cmplt, res, SS_n, SCLK, MOSI
    );

    modport master (
        output strt_cnv, chnnl, MISO,
        input  cnv_cmplt, res, SS_n, SCLK, MOSI
    );
endinterface

// File: rtl/a2d_intf.sv
// SPI master for a 12-bit ADC: two 16-bit frames per conversion, the second
// frame's returned data becomes the result.
module a2d_intf (
    input  logic        clk,
    input  logic        rst,
    a2d_intf_if.slave   bus
);
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned SHFT_W  = 16;
    localparam int unsigned SCNT_W  = 4;
    localparam int unsigned CH_W    = 3;
    localparam int unsigned RES_W   = 12;

    localparam logic [CNT_W-1:0] CNT_IDLE  = 5'b10111;
    localparam logic [CNT_W-1:0] CNT_SHIFT = 5'b10001;

    typedef enum logic [1:0] {IDLE, FRAME1, PAUSE, FRAME2} state_t;

    state_t              state,    state_n;
    logic [CNT_W-1:0]    cnt,      cnt_n;
    logic [SHFT_W-1:0]   shft,     shft_n;
    logic [SCNT_W-1:0]   shft_cnt, shft_cnt_n;
    logic [CH_W-1:0]     cmd,      cmd_n;
    logic                pause,    pause_n;
    logic                ss_n,     ss_n_n;
    logic                cmplt,    cmplt_n;
    logic [RES_W-1:0]    res,      res_n;

    logic                shift_c;
    logic                last_c;

    assign bus.SCLK      = cnt[CNT_W-1];
    assign bus.MOSI      = shft[SHFT_W-1];
    assign bus.SS_n      = ss_n;
    assign bus.cnv_cmplt = cmplt;
    assign bus.res       = res;

    // Sample point sits two clks after each SCLK rise
    assign shift_c = ((state == FRAME1) || (state == FRAME2)) && (cnt == CNT_SHIFT);
    assign last_c  = shift_c && (shft_cnt == SCNT_W'(SHFT_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= CNT_IDLE;
            shft     <= '0;
            shft_cnt <= '0;
            cmd      <= '0;
            pause    <= 1'b0;
            ss_n     <= 1'b1;
            cmplt    <= 1'b0;
            res      <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            shft     <= shft_n;
            shft_cnt <= shft_cnt_n;
            cmd      <= cmd_n;
            pause    <= pause_n;
            ss_n     <= ss_n_n;
            cmplt    <= cmplt_n;
            res      <= res_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shft_n     = shft;
        shft_cnt_n = shft_cnt;
        cmd_n      = cmd;
        pause_n    = pause;
        ss_n_n     = ss_n;
        cmplt_n    = cmplt;
        res_n      = res;

        unique case (state)
            IDLE: begin
                cnt_n = CNT_IDLE;
                if (bus.strt_cnv) begin
                    cmd_n      = bus.chnnl;
                    shft_n     = {2'b00, bus.chnnl, 11'h000};
                    shft_cnt_n = '0;
                    ss_n_n     = 1'b0;
                    cmplt_n    = 1'b0;
                    state_n    = FRAME1;
                end
            end
            FRAME1, FRAME2: begin
                cnt_n = CNT_W'(cnt + 5'd1);
                if (shift_c) begin
                    shft_n     = {shft[SHFT_W-2:0], bus.MISO};
                    shft_cnt_n = SCNT_W'(shft_cnt + 4'd1);
                end
                if (last_c) begin
                    cnt_n  = CNT_IDLE;
                    ss_n_n = 1'b1;
                    if (state == FRAME1) begin
                        pause_n = 1'b0;
                        state_n = PAUSE;
                    end else begin
                        res_n   = {shft[10:0], bus.MISO};
                        cmplt_n = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            PAUSE: begin
                cnt_n = CNT_IDLE;
                if (pause) begin
                    shft_n     = {2'b00, cmd, 11'h000};
                    shft_cnt_n = '0;
                    ss_n_n     = 1'b0;
                    state_n    = FRAME2;
                end else begin
                    pause_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
